sl_rx_scheduler: RTL and testbench
==================================

# sl_rx_scheduler

Controller and arbiter for a bank of `NCH` serial-line receivers.
- Captures each receiver's completed-word and error events into per-channel holding latches.
- Merges them through a round-robin arbiter into one shared output FIFO, tagged with channel number and error flags.
- Sequences host configuration writes to one receiver at a time, holding write-enable until the receiver's config readback matches or a timeout expires.
- Sits between the receiver bank and the host register/interrupt logic.

## Interface
Parameters:
- `NCH`, 4: number of receiver channels (2..8).
- `CONFIG_WIDTH`, 16: receiver config word width.
- `STATUS_WIDTH`, 16: receiver status word width.
- `FIFO_DEPTH`, 8: output FIFO entries; power of two, at least 2.
- `CFG_TIMEOUT`, 255: cycles to wait in WRITE for config readback.

Ports (`CW = $clog2(NCH)`, `FW = $clog2(FIFO_DEPTH)`):
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rx_status_i` in NCH*STATUS_WIDTH: per-channel status word; channel k occupies slice k.
- `rx_data_i` in NCH*32: per-channel received data word.
- `rx_changed_i` in NCH: per-channel data/status-changed pulse.
- `rx_config_i` in NCH*CONFIG_WIDTH: per-channel config readback.
- `rx_wr_config_o` out CONFIG_WIDTH: config value, shared by all channels.
- `rx_wr_enable_o` out NCH: per-channel config write enable; at most one bit set.
- `cfg_req_i` in 1: host config write request; sampled only when `cfg_busy_o`=0.
- `cfg_ch_i` in CW: target channel.
- `cfg_data_i` in CONFIG_WIDTH: config value to write.
- `cfg_busy_o` out 1: config sequencer is not IDLE.
- `cfg_done_o` out 1: one-cycle pulse, write confirmed.
- `cfg_err_o` out 1: one-cycle pulse, write rejected or timed out.
- `out_valid_o` out 1: FIFO not empty.
- `out_ready_i` in 1: pop when `out_valid_o`=1.
- `out_data_o` out 32: head entry data.
- `out_ch_o` out CW: head entry channel.
- `out_flags_o` out 3: head entry flags {LEF, PEF, WLC}.
- `out_count_o` out FW+1: FIFO occupancy.
- `overflow_o` out NCH: sticky per-channel event-lost flags.
- `ovf_clr_i` in 1: clears all `overflow_o` bits.

## Operation
Status bit positions: WLC=0, WRF=3, PEF=4, LEF=5.

Event capture, per channel k:
- Event = `rx_changed_i[k]` && (`WRF` || `LEF`). Status and data are valid in the same cycle as the pulse.
- Event latches `{LEF, PEF, WLC}` and data into the channel-k holding latch and sets `pend[k]`.
- Event while `pend[k]` is already set and not granted this cycle: overwrite the latch and set `overflow_o[k]`.
- `rx_changed_i[k]` with neither WRF nor LEF set (bit-start notifications) is ignored.

Arbiter:
- Each cycle with FIFO not full and any `pend` set, grant one channel round-robin, starting at the channel after the last granted one.
- Grant pushes that channel's latch into the FIFO and clears its `pend`.
- Grant and new event on the same channel in the same cycle: the old contents are pushed, the new event is latched, `pend` stays set, no overflow.

FIFO:
- Push is allowed only if not full at the start of the cycle.
- Pop and push in the same cycle are both performed; occupancy is unchanged.
- When full, a pop frees a slot that becomes usable on the next cycle.
- Pointers wrap modulo `FIFO_DEPTH`.
- Head entry is presented combinationally while `out_valid_o`=1.

Config sequencer states: IDLE, WRITE, RESP.
- IDLE: on `cfg_req_i`, latch channel and data and go to RESP with an error if any of these holds:
  - `cfg_ch_i` >= NCH;
  - `cfg_data_i[6:1]` < 8;
  - `cfg_data_i[1]`=1.
  Otherwise go to WRITE with the timer cleared.
- WRITE: `rx_wr_config_o` = latched data; `rx_wr_enable_o[ch]`=1; timer increments each cycle.
  - If `rx_config_i[ch]` equals the latched data: go to RESP as done.
  - Else if timer reaches `CFG_TIMEOUT`: go to RESP as error.
- RESP: pulse `cfg_done_o` or `cfg_err_o`, enable low, then IDLE.
- `cfg_busy_o`=1 in WRITE and RESP.
- `ovf_clr_i` is independent of the sequencer; a set from a new overflow in the same cycle wins over the clear.

## Timing
- Reset values: all outputs 0; `pend`=0; round-robin pointer points at channel 0 first; FIFO empty.
- Reset mid-WRITE drops the enable immediately (asynchronous).
- Event at cycle t → `pend` set at t+1 → earliest FIFO push at t+1 edge → `out_valid_o`=1 at t+2.
- Config request accepted at t:
  - WRITE from t+1.
  - If readback matches at cycle m: RESP at m+1, with `cfg_done_o` high and enable low in that cycle.
  - IDLE at m+2.
  - Readback already equal: done at t+2.
  - Invalid request: `cfg_err_o` at t+1, no enable ever asserted.
  - Timeout: enable held for `CFG_TIMEOUT`+1 cycles, then `cfg_err_o`.

## Test plan
- Ch2 event, data 0xDEADBEEF, status 0x0008 → one entry {data 0xDEADBEEF, ch 2, flags 000}; `out_valid_o` 2 cycles after the pulse.
- Events on ch0..3 in the same cycle, `out_ready_i`=1 → pops in order 0,1,2,3, one per cycle; next simultaneous burst starts at ch0 again, following the round-robin pointer.
- `out_ready_i`=0, 10 events on ch1 → `out_count_o`=8, `overflow_o[1]`=1, last event held pending; `ovf_clr_i` → 0.
- Config 0x0010 to ch3, readback matches 5 cycles after enable → `rx_wr_enable_o[3]` high exactly 5 cycles, `cfg_done_o` 1 pulse.
- Config 0x000E (quantity 7) → `cfg_err_o` next cycle, no enable; valid config with readback never matching → enable high 256 cycles, then `cfg_err_o`.
- Assert `rst_n`=0 during WRITE with FIFO holding 3 entries → enable, `out_valid_o`, `out_count_o` drop to 0 immediately.

Source files
------------

// File: rtl/sl_rx_scheduler.sv
// Receiver-bank scheduler: captures per-channel rx events, merges them round-robin
// into a tagged output FIFO, and sequences host config writes with readback confirm.
module sl_rx_scheduler #(
  parameter int NCH          = 4,
  parameter int CONFIG_WIDTH = 16,
  parameter int STATUS_WIDTH = 16,
  parameter int FIFO_DEPTH   = 8,
  parameter int CFG_TIMEOUT  = 255,
  localparam int CW = $clog2(NCH),
  localparam int FW = $clog2(FIFO_DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NCH*STATUS_WIDTH-1:0]  rx_status_i,
  input  logic [NCH*32-1:0]            rx_data_i,
  input  logic [NCH-1:0]               rx_changed_i,
  input  logic [NCH*CONFIG_WIDTH-1:0]  rx_config_i,
  output logic [CONFIG_WIDTH-1:0]      rx_wr_config_o,
  output logic [NCH-1:0]               rx_wr_enable_o,
  input  logic                         cfg_req_i,
  input  logic [CW-1:0]                cfg_ch_i,
  input  logic [CONFIG_WIDTH-1:0]      cfg_data_i,
  output logic                         cfg_busy_o,
  output logic                         cfg_done_o,
  output logic                         cfg_err_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [31:0]                  out_data_o,
  output logic [CW-1:0]                out_ch_o,
  output logic [2:0]                   out_flags_o,
  output logic [FW:0]                  out_count_o,
  output logic [NCH-1:0]               overflow_o,
  input  logic                         ovf_clr_i
);

  localparam int TW  = (CFG_TIMEOUT < 1) ? 1 : $clog2(CFG_TIMEOUT + 1);
  localparam int EW  = 32 + CW + 3;
  localparam int WLC = 0;
  localparam int WRF = 3;
  localparam int PEF = 4;
  localparam int LEF = 5;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_RESP} cfg_state_e;

  logic [NCH-1:0]          ev;
  logic [31:0]             lat_data_q  [NCH];
  logic [2:0]              lat_flags_q [NCH];
  logic [NCH-1:0]          pend_q, pend_d;
  logic [NCH-1:0]          ovf_q, ovf_d;
  logic [NCH-1:0]          gnt;
  logic [CW-1:0]           rr_q, rr_d;
  logic [CW-1:0]           gnt_idx;
  logic                    gnt_any;
  int                      scan_idx;

  logic [EW-1:0]           mem_q [FIFO_DEPTH];
  logic [FW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [FW:0]             count_q, count_d;
  logic                    full, push, pop;
  logic [EW-1:0]           head;

  cfg_state_e              state_q;
  logic [CW-1:0]           ch_q;
  logic [CONFIG_WIDTH-1:0] data_q;
  logic [TW-1:0]           timer_q;
  logic [NCH-1:0]          en_q;
  logic                    done_q, err_q;
  logic                    req_bad, rb_match;

  // Only word-complete (WRF) or line-error (LEF) notifications are events.
  always_comb begin
    ev = '0;
    for (int k = 0; k < NCH; k++) begin
      ev[k] = rx_changed_i[k] &
              (rx_status_i[k*STATUS_WIDTH + WRF] | rx_status_i[k*STATUS_WIDTH + LEF]);
    end
  end

  assign full = (count_q == (FW+1)'(FIFO_DEPTH));

  // Scan downward so the pending channel closest after rr_q is the one kept.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    scan_idx = 0;
    for (int i = NCH - 1; i >= 0; i--) begin
      scan_idx = (int'(rr_q) + i) % NCH;
      if (pend_q[scan_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = CW'(scan_idx);
      end
    end
    if (full) begin
      gnt_any = 1'b0;
    end
  end

  always_comb begin
    gnt = '0;
    if (gnt_any) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

  assign push    = gnt_any;
  assign pop     = out_ready_i & (count_q != '0);
  assign pend_d  = ev | (pend_q & ~gnt);
  assign ovf_d   = (ev & pend_q & ~gnt) | (ovf_q & ~{NCH{ovf_clr_i}});
  assign count_d = count_q + (FW+1)'(push) - (FW+1)'(pop);
  assign rr_d    = (gnt_idx == CW'(NCH - 1)) ? '0 : gnt_idx + CW'(1);

  // Latch and FIFO storage carry no reset; validity is tracked by pend_q and count_q.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NCH; k++) begin
      if (ev[k]) begin
        lat_data_q[k]  <= rx_data_i[k*32 +: 32];
        lat_flags_q[k] <= {rx_status_i[k*STATUS_WIDTH + LEF],
                           rx_status_i[k*STATUS_WIDTH + PEF],
                           rx_status_i[k*STATUS_WIDTH + WLC]};
      end
    end
    if (push) begin
      mem_q[wr_ptr_q] <= {lat_data_q[gnt_idx], gnt_idx, lat_flags_q[gnt_idx]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q   <= '0;
      ovf_q    <= '0;
      rr_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
      if (gnt_any) begin
        rr_q <= rr_d;
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + FW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + FW'(1);
      end
    end
  end

  assign head        = mem_q[rd_ptr_q];
  assign out_valid_o = (count_q != '0);
  assign out_data_o  = out_valid_o ? head[EW-1 -: 32] : '0;
  assign out_ch_o    = out_valid_o ? head[3 +: CW]    : '0;
  assign out_flags_o = out_valid_o ? head[2:0]        : '0;
  assign out_count_o = count_q;
  assign overflow_o  = ovf_q;

  // Quantity field is cfg_data[6:1]; odd quantities (bit 1) and values below 8 are rejected.
  assign req_bad  = ({1'b0, cfg_ch_i} >= (CW+1)'(NCH)) | (cfg_data_i[6:1] < 6'd8) |
                    cfg_data_i[1];
  assign rb_match = (rx_config_i[ch_q*CONFIG_WIDTH +: CONFIG_WIDTH] == data_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      data_q  <= '0;
      timer_q <= '0;
      en_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cfg_req_i) begin
            ch_q    <= cfg_ch_i;
            data_q  <= cfg_data_i;
            timer_q <= '0;
            if (req_bad) begin
              state_q <= S_RESP;
              err_q   <= 1'b1;
            end else begin
              state_q <= S_WRITE;
              en_q    <= NCH'(1) << cfg_ch_i;
            end
          end
        end
        S_WRITE: begin
          timer_q <= timer_q + TW'(1);
          if (rb_match) begin
            state_q <= S_RESP;
            done_q  <= 1'b1;
            en_q    <= '0;
          end else if (timer_q == TW'(CFG_TIMEOUT)) begin
            state_q <= S_RESP;
            err_q   <= 1'b1;
            en_q    <= '0;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          en_q    <= '0;
        end
      endcase
    end
  end

  assign rx_wr_config_o = data_q;
  assign rx_wr_enable_o = en_q;
  assign cfg_busy_o     = (state_q != S_IDLE);
  assign cfg_done_o     = done_q;
  assign cfg_err_o      = err_q;

endmodule

// File: tb/tb_sl_rx_scheduler.sv
// Bench for sl_rx_scheduler: vector table, directed arbiter/config/reset sequences,
// and randomized event traffic against a queue-based reference model.
module tb_sl_rx_scheduler;

  localparam int NCH   = 4;
  localparam int CFGW  = 16;
  localparam int STW   = 16;
  localparam int DEPTH = 8;
  localparam int TMO   = 255;
  localparam int CW    = 2;
  localparam int FW    = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NCH*STW-1:0]  rx_status_i = '0;
  logic [NCH*32-1:0]   rx_data_i = '0;
  logic [NCH-1:0]      rx_changed_i = '0;
  logic [NCH*CFGW-1:0] rx_config_i = '0;
  logic [CFGW-1:0]     rx_wr_config_o;
  logic [NCH-1:0]      rx_wr_enable_o;
  logic                cfg_req_i = 1'b0;
  logic [CW-1:0]       cfg_ch_i = '0;
  logic [CFGW-1:0]     cfg_data_i = '0;
  logic                cfg_busy_o, cfg_done_o, cfg_err_o;
  logic                out_valid_o;
  logic                out_ready_i = 1'b0;
  logic [31:0]         out_data_o;
  logic [CW-1:0]       out_ch_o;
  logic [2:0]          out_flags_o;
  logic [FW:0]         out_count_o;
  logic [NCH-1:0]      overflow_o;
  logic                ovf_clr_i = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  sl_rx_scheduler #(.NCH(NCH), .CONFIG_WIDTH(CFGW), .STATUS_WIDTH(STW),
                    .FIFO_DEPTH(DEPTH), .CFG_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_status_i(rx_status_i), .rx_data_i(rx_data_i), .rx_changed_i(rx_changed_i),
    .rx_config_i(rx_config_i), .rx_wr_config_o(rx_wr_config_o),
    .rx_wr_enable_o(rx_wr_enable_o),
    .cfg_req_i(cfg_req_i), .cfg_ch_i(cfg_ch_i), .cfg_data_i(cfg_data_i),
    .cfg_busy_o(cfg_busy_o), .cfg_done_o(cfg_done_o), .cfg_err_o(cfg_err_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_ch_o(out_ch_o), .out_flags_o(out_flags_o), .out_count_o(out_count_o),
    .overflow_o(overflow_o), .ovf_clr_i(ovf_clr_i)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    int          ch;
    logic [15:0] st;
    logic [31:0] d;
    logic        ev;
    logic [2:0]  fl;
  } vec_t;

  vec_t vt[6];

  // Reference model state: pending latches, rr start, FIFO contents as a queue.
  logic [36:0]    mq[$];
  logic           mpend[NCH];
  logic [31:0]    mdata[NCH];
  logic [2:0]     mfl[NCH];
  logic [NCH-1:0] movf;
  int             mrr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_ch(input int k, input logic chg, input logic [15:0] st, input logic [31:0] d);
    rx_changed_i[k]        = chg;
    rx_status_i[k*STW +: STW] = st;
    rx_data_i[k*32 +: 32]  = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rx_changed_i = '0;
    out_ready_i = 1'b0;
    ovf_clr_i = 1'b0;
    cfg_req_i = 1'b0;
    rx_config_i = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic model_reset();
    mq.delete();
    for (int k = 0; k < NCH; k++) begin
      mpend[k] = 1'b0;
      mdata[k] = '0;
      mfl[k] = '0;
    end
    movf = '0;
    mrr = 0;
  endtask

  // Advances the model across one clock edge with the inputs currently driven.
  task automatic model_step();
    logic        pop_m;
    logic        full_m;
    int          g;
    int          c;
    logic [15:0] st;
    pop_m  = out_ready_i && (mq.size() > 0);
    full_m = (mq.size() == DEPTH);
    g = -1;
    if (!full_m) begin
      for (int i = 0; i < NCH; i++) begin
        c = (mrr + i) % NCH;
        if (g < 0 && mpend[c]) g = c;
      end
    end
    if (pop_m) void'(mq.pop_front());
    if (g >= 0) begin
      mq.push_back({mdata[g], 2'(g), mfl[g]});
      mpend[g] = 1'b0;
      mrr = (g + 1) % NCH;
    end
    if (ovf_clr_i) movf = '0;
    for (int k = 0; k < NCH; k++) begin
      st = rx_status_i[k*STW +: STW];
      if (rx_changed_i[k] && (st[3] || st[5])) begin
        if (mpend[k]) movf[k] = 1'b1;
        mpend[k] = 1'b1;
        mdata[k] = rx_data_i[k*32 +: 32];
        mfl[k]   = {st[5], st[4], st[0]};
      end
    end
  endtask

  task automatic burst_check(input string tag, input logic [3:0] mask, input int ord[4], input int n);
    for (int k = 0; k < NCH; k++) set_ch(k, mask[k], 16'h0008, 32'hA000_0000 + k);
    tick();
    rx_changed_i = '0;
    tick();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s valid%0d", tag, i), out_valid_o, 1'b1);
      check($sformatf("%s ch%0d", tag, i), out_ch_o, ord[i]);
      check($sformatf("%s data%0d", tag, i), out_data_o, 32'hA000_0000 + ord[i]);
      tick();
    end
    check($sformatf("%s drained", tag), out_valid_o, 1'b0);
  endtask

  initial begin
    int          en_cnt;
    int          done_cnt;
    int          err_cnt;
    logic        rb_set;
    logic [31:0] got[$];
    int          ord[4];

    vt[0] = '{2, 16'h0008, 32'hDEADBEEF, 1'b1, 3'b000};
    vt[1] = '{0, 16'h0020, 32'h12345678, 1'b1, 3'b100};
    vt[2] = '{1, 16'h0039, 32'hCAFEF00D, 1'b1, 3'b111};
    vt[3] = '{3, 16'h0011, 32'h55555555, 1'b0, 3'b000};
    vt[4] = '{3, 16'h0019, 32'h0BADC0DE, 1'b1, 3'b011};
    vt[5] = '{1, 16'hFFD6, 32'h77777777, 1'b0, 3'b000};

    // Reset state while rst_n is held low.
    repeat (2) tick();
    check("rst valid", out_valid_o, 1'b0);
    check("rst count", out_count_o, '0);
    check("rst data", out_data_o, '0);
    check("rst enable", rx_wr_enable_o, '0);
    check("rst wrcfg", rx_wr_config_o, '0);
    check("rst busy", cfg_busy_o, 1'b0);
    check("rst done", cfg_done_o, 1'b0);
    check("rst err", cfg_err_o, 1'b0);
    check("rst ovf", overflow_o, '0);
    rst_n = 1'b1;
    tick();

    // Single-event vectors: latency, tagging, flag extraction, ignored notifications.
    for (int i = 0; i < 6; i++) begin
      set_ch(vt[i].ch, 1'b1, vt[i].st, vt[i].d);
      tick();
      rx_changed_i = '0;
      check($sformatf("vec%0d early", i), out_valid_o, 1'b0);
      tick();
      check($sformatf("vec%0d valid", i), out_valid_o, vt[i].ev);
      if (vt[i].ev) begin
        check($sformatf("vec%0d data", i), out_data_o, vt[i].d);
        check($sformatf("vec%0d ch", i), out_ch_o, vt[i].ch);
        check($sformatf("vec%0d flags", i), out_flags_o, vt[i].fl);
        check($sformatf("vec%0d count", i), out_count_o, 1);
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        check($sformatf("vec%0d popped", i), out_count_o, 0);
      end
    end

    // Round-robin bursts.
    do_reset();
    out_ready_i = 1'b1;
    ord = '{0, 1, 2, 3};
    burst_check("burstA", 4'b1111, ord, 4);
    burst_check("burstB", 4'b1111, ord, 4);
    ord = '{1, 0, 0, 0};
    burst_check("single1", 4'b0010, ord, 1);
    ord = '{2, 3, 0, 1};
    burst_check("burstC", 4'b1111, ord, 4);
    out_ready_i = 1'b0;

    // Overflow with a stalled consumer.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      set_ch(1, 1'b1, 16'h0008, 32'h100 + i);
      tick();
    end
    rx_changed_i = '0;
    tick();
    check("ovf count full", out_count_o, 8);
    check("ovf flag", overflow_o, 4'b0010);
    ovf_clr_i = 1'b1;
    tick();
    ovf_clr_i = 1'b0;
    check("ovf cleared", overflow_o, 4'b0000);
    out_ready_i = 1'b1;
    got.delete();
    for (int i = 0; i < 30; i++) begin
      if (out_valid_o) got.push_back(out_data_o);
      tick();
    end
    out_ready_i = 1'b0;
    check("ovf drain size", got.size(), 9);
    for (int i = 0; i < 9 && i < got.size(); i++) begin
      check($sformatf("ovf drain%0d", i), got[i], (i < 8) ? 32'h100 + i : 32'h109);
    end

    // Config write confirmed on the fifth enable cycle.
    cfg_req_i = 1'b1; cfg_ch_i = 2'd3; cfg_data_i = 16'h0010;
    en_cnt = 0; done_cnt = 0; err_cnt = 0; rb_set = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      cfg_req_i = 1'b0;
      if (rx_wr_enable_o == 4'b1000) begin
        en_cnt++;
        if (en_cnt == 1) check("cfg wrcfg", rx_wr_config_o, 16'h0010);
      end else if (rx_wr_enable_o != 4'b0000) begin
        check("cfg stray enable", rx_wr_enable_o, 4'b1000);
      end
      if (cfg_done_o) done_cnt++;
      if (cfg_err_o) err_cnt++;
      if (en_cnt == 5 && !rb_set) begin
        rx_config_i[3*CFGW +: CFGW] = 16'h0010;
        rb_set = 1'b1;
      end
    end
    check("cfg enable cycles", en_cnt, 5);
    check("cfg done pulses", done_cnt, 1);
    check("cfg err pulses", err_cnt, 0);
    check("cfg idle after", cfg_busy_o, 1'b0);
    rx_config_i = '0;

    // Readback already equal: done two cycles after the request.
    rx_config_i[0 +: CFGW] = 16'h0020;
    cfg_req_i = 1'b1; cfg_ch_i = 2'd0; cfg_data_i = 16'h0020;
    tick();
    cfg_req_i = 1'b0;
    check("eq t1 enable", rx_wr_enable_o, 4'b0001);
    check("eq t1 done", cfg_done_o, 1'b0);
    check("eq t1 busy", cfg_busy_o, 1'b1);
    tick();
    check("eq t2 done", cfg_done_o, 1'b1);
    check("eq t2 enable", rx_wr_enable_o, 4'b0000);
    tick();
    check("eq t3 busy", cfg_busy_o, 1'b0);
    rx_config_i = '0;

    // Rejected requests: quantity below 8, and odd quantity.
    cfg_req_i = 1'b1; cfg_ch_i = 2'd2; cfg_data_i = 16'h000E;
    tick();
    cfg_req_i = 1'b0;
    check("bad7 err", cfg_err_o, 1'b1);
    check("bad7 enable", rx_wr_enable_o, 4'b0000);
    tick();
    check("bad7 err end", cfg_err_o, 1'b0);
    check("bad7 idle", cfg_busy_o, 1'b0);
    cfg_req_i = 1'b1; cfg_ch_i = 2'd1; cfg_data_i = 16'h0012;
    tick();
    cfg_req_i = 1'b0;
    check("odd err", cfg_err_o, 1'b1);
    check("odd enable", rx_wr_enable_o, 4'b0000);
    tick();

    // Timeout: readback never matches.
    cfg_req_i = 1'b1; cfg_ch_i = 2'd1; cfg_data_i = 16'h0030;
    en_cnt = 0; done_cnt = 0; err_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      cfg_req_i = 1'b0;
      if (rx_wr_enable_o == 4'b0010) en_cnt++;
      if (cfg_done_o) done_cnt++;
      if (cfg_err_o) err_cnt++;
    end
    check("tmo enable cycles", en_cnt, TMO + 1);
    check("tmo err pulses", err_cnt, 1);
    check("tmo done pulses", done_cnt, 0);

    // Randomized event traffic against the reference model.
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      check("rnd valid", out_valid_o, mq.size() != 0);
      check("rnd count", out_count_o, mq.size());
      check("rnd ovf", overflow_o, movf);
      if (mq.size() != 0) begin
        check("rnd data", out_data_o, mq[0][36:5]);
        check("rnd ch", out_ch_o, mq[0][4:3]);
        check("rnd flags", out_flags_o, mq[0][2:0]);
      end
      for (int k = 0; k < NCH; k++) begin
        set_ch(k, ($urandom_range(0, 9) < 3), 16'($urandom), $urandom);
      end
      out_ready_i = ($urandom_range(0, 2) != 0);
      ovf_clr_i   = ($urandom_range(0, 19) == 0);
      model_step();
      tick();
    end
    rx_changed_i = '0;
    out_ready_i = 1'b0;
    ovf_clr_i = 1'b0;

    // Asynchronous reset mid-WRITE with three FIFO entries.
    do_reset();
    for (int k = 0; k < 3; k++) set_ch(k, 1'b1, 16'h0008, 32'h300 + k);
    tick();
    rx_changed_i = '0;
    repeat (4) tick();
    check("arst pre count", out_count_o, 3);
    cfg_req_i = 1'b1; cfg_ch_i = 2'd0; cfg_data_i = 16'h0040;
    tick();
    cfg_req_i = 1'b0;
    tick();
    check("arst pre enable", rx_wr_enable_o, 4'b0001);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst enable", rx_wr_enable_o, 4'b0000);
    check("arst valid", out_valid_o, 1'b0);
    check("arst count", out_count_o, 0);
    check("arst busy", cfg_busy_o, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
